// File: rtl/sprite_line_fetch_if.sv
// ---------------------------------------------------------------------------
// sprite_line_fetch_if
// Bundle of the signals between the print engine / sprite memory / VGA pixel
// path (master side) and the sprite line fetcher (slave side).
//   sprite_on       master->slave  job request, level
//   sprite_datas    master->slave  32-bit sprite word
//   pixel_y         master->slave  current raster line
//   mem_data        master->slave  sprite memory read data (1-cycle latency)
//   memory_address  slave->master  sprite memory read address
//   pixel_color     slave->master  colour of the current pixel
//   pixel_col       slave->master  column index of pixel_color
//   pixel_valid     slave->master  pixel_color / pixel_col valid
//   count_finished  slave->master  one-cycle pulse when the line is done
//   busy            slave->master  fetcher not idle
// ---------------------------------------------------------------------------
interface sprite_line_fetch_if #(
    parameter int SIZE_X       = 10,
    parameter int SIZE_Y       = 10,
    parameter int SIZE_ADDRESS = 14,
    parameter int COLOR_W      = 9
);
    logic                    sprite_on;
    logic [31:0]             sprite_datas;
    logic [SIZE_Y-1:0]       pixel_y;
    logic [COLOR_W-1:0]      mem_data;
    logic [SIZE_ADDRESS-1:0] memory_address;
    logic [COLOR_W-1:0]      pixel_color;
    logic [SIZE_X-1:0]       pixel_col;
    logic                    pixel_valid;
    logic                    count_finished;
    logic                    busy;

    modport master (
        output sprite_on, sprite_datas, pixel_y, mem_data,
        input  memory_address, pixel_color, pixel_col, pixel_valid,
               count_finished, busy
    );

    modport slave (
        input  sprite_on, sprite_datas, pixel_y, mem_data,
        output memory_address, pixel_color, pixel_col, pixel_valid,
               count_finished, busy
    );
endinterface

// File: rtl/sprite_line_fetch.sv
// ---------------------------------------------------------------------------
// sprite_line_fetch
// Consumer end of the print-engine sprite handshake. On a rising edge of
// sprite_on it latches the sprite word and raster line, works out which
// sprite row is on this raster line, walks that row in sprite memory one
// address per cycle and streams the returned colours to the pixel path.
// A one-cycle count_finished pulse marks the end of the line.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous reset, active-high
//   bus    sprite_line_fetch_if.slave (handshake, memory and pixel signals)
//
// Sprite word: [29:20] x, [19:10] y, [4:0] id, [30] mirror, rest reserved.
// Optional feature macro: SPRITE_MIRROR_EN -- when defined, bit [30] of the
// sprite word reverses the address order of the line (pixel_col still counts
// in screen order). When undefined, bit [30] has no effect.
// ---------------------------------------------------------------------------
module sprite_line_fetch #(
    parameter int SIZE_X       = 10,
    parameter int SIZE_Y       = 10,
    parameter int SIZE_ADDRESS = 14,
    parameter int SPRITE_W     = 20,
    parameter int SPRITE_H     = 20,
    parameter int COLOR_W      = 9
) (
    input  logic               clk,
    input  logic               reset,
    sprite_line_fetch_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic                    sprite_on_prev_reg;
    logic [9:0]              sprite_y_reg;
    logic [4:0]              sprite_id_reg;
    logic                    mirror_reg;
    logic                    background_reg;
    logic [SIZE_Y-1:0]       pixel_y_reg;
    logic [SIZE_ADDRESS-1:0] base_reg, base_next;
    logic [SIZE_ADDRESS-1:0] addr_reg, addr_next;
    logic [SIZE_X-1:0]       col_reg, col_next;
    logic                    pixel_valid_reg, pixel_valid_next;
    logic [SIZE_X-1:0]       pixel_col_reg, pixel_col_next;

    logic                    rise;
    logic [SIZE_Y-1:0]       row;
    logic                    skip_line;
    logic [31:0]             base_full;
    logic [SIZE_ADDRESS-1:0] base_calc;

    // Address of column c of the line starting at b; mirrored lines walk the
    // memory backwards while the column counter still runs forwards.
    function automatic logic [SIZE_ADDRESS-1:0] addr_of(
        input logic [SIZE_ADDRESS-1:0] b,
        input logic [SIZE_X-1:0]       c,
        input logic                    m
    );
        logic [SIZE_X-1:0] off;
        off = m ? (SIZE_X'(SPRITE_W - 1) - c) : c;
        return SIZE_ADDRESS'(32'(b) + 32'(off));
    endfunction

    assign rise = bus.sprite_on & ~sprite_on_prev_reg;

    // Row wraps mod 2^SIZE_Y, so a raster line above the sprite gives a huge
    // row value and falls into the skip path.
    assign row       = pixel_y_reg - SIZE_Y'(sprite_y_reg);
    assign skip_line = background_reg || (row >= SIZE_Y'(SPRITE_H));
    assign base_full = 32'(sprite_id_reg) * 32'(SPRITE_W * SPRITE_H)
                     + 32'(row) * 32'(SPRITE_W);
    assign base_calc = SIZE_ADDRESS'(base_full);

    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        addr_next        = addr_reg;
        col_next         = col_reg;
        pixel_valid_next = 1'b0;
        pixel_col_next   = pixel_col_reg;

        unique case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (!bus.sprite_on) begin
                    state_next = IDLE;
                end else if (skip_line) begin
                    state_next = DONE;
                end else begin
                    base_next  = base_calc;
                    col_next   = '0;
                    addr_next  = addr_of(base_calc, '0, mirror_reg);
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!bus.sprite_on) begin
                    state_next = IDLE;
                end else begin
                    // The address issued this cycle returns data next cycle,
                    // so tag that cycle's pixel with the current column.
                    pixel_valid_next = 1'b1;
                    pixel_col_next   = col_reg;
                    if (col_reg == SIZE_X'(SPRITE_W - 1)) begin
                        state_next = DRAIN;
                    end else begin
                        col_next  = col_reg + 1'b1;
                        addr_next = addr_of(base_reg, col_reg + 1'b1, mirror_reg);
                    end
                end
            end
            DRAIN: begin
                state_next = bus.sprite_on ? DONE : IDLE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            sprite_on_prev_reg <= 1'b0;
            sprite_y_reg       <= '0;
            sprite_id_reg      <= '0;
            mirror_reg         <= 1'b0;
            background_reg     <= 1'b0;
            pixel_y_reg        <= '0;
            base_reg           <= '0;
            addr_reg           <= '0;
            col_reg            <= '0;
            pixel_valid_reg    <= 1'b0;
            pixel_col_reg      <= '0;
        end else begin
            state_reg          <= state_next;
            sprite_on_prev_reg <= bus.sprite_on;
            base_reg           <= base_next;
            addr_reg           <= addr_next;
            col_reg            <= col_next;
            pixel_valid_reg    <= pixel_valid_next;
            pixel_col_reg      <= pixel_col_next;
            if (state_reg == IDLE && rise) begin
                sprite_y_reg   <= bus.sprite_datas[19:10];
                sprite_id_reg  <= bus.sprite_datas[4:0];
                background_reg <= (bus.sprite_datas == 32'h0000_0001);
                pixel_y_reg    <= bus.pixel_y;
`ifdef SPRITE_MIRROR_EN
                mirror_reg     <= bus.sprite_datas[30];
`else
                mirror_reg     <= 1'b0;
`endif
            end
        end
    end

    // Memory data arrives one cycle after its address, exactly when
    // pixel_valid is high, so the colour is passed straight through and
    // forced to zero outside valid pixels.
    assign bus.memory_address = addr_reg;
    assign bus.pixel_color    = pixel_valid_reg ? bus.mem_data : '0;
    assign bus.pixel_col      = pixel_col_reg;
    assign bus.pixel_valid    = pixel_valid_reg;
    assign bus.count_finished = (state_reg == DONE);
    assign bus.busy           = (state_reg != IDLE);

endmodule
